sram_ctrl: RTL
==============

# sram_ctrl

Parametrised external asynchronous-SRAM controller with two requesting ports and round-robin arbitration, replacing the ad-hoc chip-select/READY wait-state logic in the board top level. Port 0 serves the debug UART memory path and port 1 serves the b16 CPU. Both ports are served over a single SRAM bus using runtime-programmable read and write wait states and per-byte write enables. Each port uses a req/ack handshake, so a master stalls simply by holding `req`.

## Interface
Parameters:
- `AW`, 15, SRAM word-address width.
- `DW`, 16, data width; must be a multiple of 8.
- `BW`, DW/8, number of byte lanes (derived; do not override).
- `WW`, 4, width of the wait-state configuration inputs.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_rd_wait`  in  WW  extra ACCESS cycles for reads.
- `cfg_wr_wait`  in  WW  extra ACCESS cycles for writes.
- `m0_req`, `m1_req`  in  1  access request; held until ack.
- `m0_addr`, `m1_addr`  in  AW  word address.
- `m0_we`, `m1_we`  in  BW  byte write mask; all-zero means read.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_rdata`, `m1_rdata`  out  DW  read data; valid while ack=1, held until that port's next read.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `sram_addr`  out  AW  SRAM address.
- `sram_dq_i`  in  DW  SRAM data in.
- `sram_dq_o`  out  DW  SRAM data out.
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_o`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1  SRAM strobes, active-low.
- `sram_be_n`  out  BW  byte-lane enables, active-low.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE: arbitrate among ports with `req`=1.
  - If only one requests, it wins.
  - If both request, the port not granted last wins. The last-grant pointer resets to 1, so port 0 wins the first tie.
- On grant: latch port index, addr, we, wdata. Load the counter with `cfg_rd_wait` (read) or `cfg_wr_wait` (write).
  - Configuration is sampled only here; changes mid-access are ignored.
- Read path:
  - IDLE → ACCESS with ce_n=0, oe_n=0, be_n=0.
  - In ACCESS, if count==0: capture `sram_dq_i` into the granted port's rdata, then go to DONE. Otherwise decrement the counter and stay in ACCESS.
- Write path:
  - IDLE → SETUP: ce_n=0, we_n=1, dq_oe=1, be_n=~we.
  - SETUP → ACCESS: we_n=0, counting as for reads.
  - ACCESS → HOLD: we_n=1, dq_oe and ce_n still asserted.
  - HOLD → DONE.
- DONE: all strobes high, dq_oe=0, ack=1 for the granted port only, then → IDLE.
- `sram_addr` and `sram_dq_o` hold the latched values from grant through DONE.
- `sram_dq_oe` is never 1 while `sram_oe_n`=0; no bus contention.
- Masters deassert `req` on the edge where they see ack. A `req` still high in the following IDLE cycle is a new access.
- Reset, including mid-access: → IDLE next edge; no ack for the aborted access; pointer reset.

## Timing
Latency is counted from the edge at which IDLE samples `req` until ack is high. W is the sampled wait count.
- Read: ACCESS lasts W+1 cycles; ack high W+2 cycles after the grant edge. Minimum 2 (W=0).
- Write: SETUP 1 + ACCESS W+1 + HOLD 1; ack high W+4 cycles after the grant edge. Minimum 4.
- Back-to-back: one IDLE cycle between DONE and the next grant. Zero-wait read throughput is 1 access per 3 cycles.
- Reset values of outputs:
  - `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1; `sram_be_n`=all 1.
  - `sram_dq_oe`=0; `sram_addr`=0; `sram_dq_o`=0.
  - `m*_ack`=0; `m*_rdata`=0; `busy`=0.
- All outputs are registered (decoded from registered state/latches); no combinational path from req to SRAM pins.

## Structure
- Package `mem_pkg`:
  - State enum (IDLE, SETUP, ACCESS, HOLD, DONE).
  - Port index constants `PORT_DBG`=0, `PORT_CPU`=1.
  - Default `AW`/`DW`/`WW` constants.
- Sub-module `rr_arb2`: two-request round-robin arbiter with last-grant pointer and a `take` strobe. Reused later for bootram sharing.
- Top of `sram_ctrl`: FSM, wait counter, request latches, rdata registers.

## Test plan
- Reset, then a port-1 read of addr 0x0123 with rd_wait=0; SRAM model returns 0xBEEF → `m1_ack` on cycle 2, `m1_rdata`=0xBEEF, oe_n low for exactly 1 cycle.
- Port-1 write of 0xA55A to 0x0040 with we=2'b01 and wr_wait=3 → we_n low 4 cycles, be_n=2'b10, ack at cycle 7. Readback returns low byte 0x5A with the high byte unchanged.
- Both ports request in the same cycle, repeatedly → grants alternate 0,1,0,1; each port gets exactly one ack per access; dq_oe never overlaps oe_n=0.
- Change `cfg_rd_wait` from 2 to 7 during ACCESS → the access still completes with 2 waits; the next access uses 7.
- Assert reset during a write's ACCESS state → next cycle we_n=1, ce_n=1, dq_oe=0, busy=0; no ack; memory model flags no partial-strobe glitch.
- Port 0 keeps `req` high after ack → a second access is granted after one IDLE cycle. If port 1 is waiting, port 1 wins that arbitration instead.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the external SRAM controller and its arbiter.
// Default widths match the board SRAM (32K x 16).
package mem_pkg;

  localparam int DEF_AW = 15;
  localparam int DEF_DW = 16;
  localparam int DEF_WW = 4;

  localparam logic PORT_DBG = 1'b0;
  localparam logic PORT_CPU = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/sram_ctrl_rr_arb2.sv
// Two-request round-robin arbiter; the last-grant pointer only advances on take,
// so a grant the owner does not act on never steals fairness from the other port.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt_idx = ~last_q;
    else              gnt_idx = req[1];
  end

  // Pointer resets to the CPU port so the debug port wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)                  last_q <= PORT_CPU;
    else if (take && gnt_valid) last_q <= gnt_idx;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Dual-port asynchronous SRAM controller: round-robin arbitration, programmable
// read/write wait states, per-byte write enables; every pin is driven from a flop.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int BW = DW / 8,
  parameter int WW = DEF_WW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [WW-1:0] cfg_rd_wait,
  input  logic [WW-1:0] cfg_wr_wait,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [BW-1:0] m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [BW-1:0] m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dq_i,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [BW-1:0] sram_be_n,
  output logic          busy
);

  state_t        state;
  logic          port_q;
  logic          is_write;
  logic [WW-1:0] count;

  logic          gnt_valid;
  logic          gnt_idx;
  logic          take;
  logic [AW-1:0] sel_addr;
  logic [BW-1:0] sel_we;
  logic [DW-1:0] sel_wdata;

  assign take = (state == IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({m1_req, m0_req}),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_addr  = m0_addr;
    sel_we    = m0_we;
    sel_wdata = m0_wdata;
    if (gnt_idx == PORT_CPU) begin
      sel_addr  = m1_addr;
      sel_we    = m1_we;
      sel_wdata = m1_wdata;
    end
  end

  // Strobes are set one state ahead so each pin leaves a flop with the state;
  // dq_oe is only raised on the write path, so it never meets oe_n low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      port_q     <= PORT_DBG;
      is_write   <= 1'b0;
      count      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            port_q    <= gnt_idx;
            sram_addr <= sel_addr;
            sram_dq_o <= sel_wdata;
            sram_ce_n <= 1'b0;
            busy      <= 1'b1;
            if (sel_we == '0) begin
              is_write  <= 1'b0;
              count     <= cfg_rd_wait;
              sram_oe_n <= 1'b0;
              sram_be_n <= '0;
              state     <= ACCESS;
            end else begin
              is_write   <= 1'b1;
              count      <= cfg_wr_wait;
              sram_dq_oe <= 1'b1;
              sram_be_n  <= ~sel_we;
              state      <= SETUP;
            end
          end
        end
        SETUP: begin
          sram_we_n <= 1'b0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - WW'(1);
          end else if (is_write) begin
            sram_we_n <= 1'b1;
            state     <= HOLD;
          end else begin
            if (port_q == PORT_DBG) begin
              m0_rdata <= sram_dq_i;
              m0_ack   <= 1'b1;
            end else begin
              m1_rdata <= sram_dq_i;
              m1_ack   <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
            state     <= DONE;
          end
        end
        HOLD: begin
          if (port_q == PORT_DBG) m0_ack <= 1'b1;
          else                    m1_ack <= 1'b1;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_be_n  <= '1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
